decoder_2_4_strobe: RTL and testbench
=====================================

# decoder_2_4_strobe

Sequenced 2-to-4 decoder, the receiving end of the 4-to-2 encoder path. It accepts a 2-bit code over a valid/ready handshake and drives the matching one-hot output for a programmable number of cycles. An optional guard gap follows each pulse. Used wherever an encoded select must be expanded back into timed one-hot strobes, for example for line drivers or enable fan-out, with completion and count status for the controlling logic.

## Interface
Parameters:
- PULSE_LEN, 4: cycles each one-hot output is held high; legal 1..255; 0 is an elaboration error.
- GAP_LEN, 1: idle cycles forced after each completed pulse; legal 0..255.
- CNT_W, 8: width of the completed-pulse counter.

Ports:
- clk, input, 1: sole clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- e, input, 1: enable; low blocks acceptance and aborts an active pulse.
- in_valid, input, 1: code is valid this cycle.
- in_ready, output, 1: block can accept a code this cycle.
- code, input, 2: encoded select; 0 selects y[0] through 3 selects y[3].
- y, output, 4: one-hot strobe output; all-zero when not driving.
- busy, output, 1: high whenever state is not IDLE.
- done, output, 1: high during the final driven cycle of a pulse that was not aborted.
- count, output, CNT_W: number of completed (non-aborted) pulses; saturates at all ones.

## Operation
- Reset: state IDLE, y=0, done=0, busy=0, count=0, internal down-counter=0. in_ready=0 while rst is high.
- FSM states: IDLE, DRIVE, GAP.
- in_ready = e AND (state==IDLE) AND NOT rst. It is a combinational function of registered state and inputs.
- Accept: in_valid AND in_ready at an edge. The edge latches code, loads the down-counter with PULSE_LEN-1 and enters DRIVE. There is no acceptance outside IDLE. in_valid with in_ready low is ignored, with no queueing.
- DRIVE: y = 1 << latched code. The down-counter decrements each cycle. done = (cnt==0) in DRIVE.
  - When cnt==0 and e=1, the next state is GAP with cnt=GAP_LEN-1, or IDLE if GAP_LEN==0. count increments by 1 unless already saturated.
- GAP: y=0. cnt decrements. When cnt==0, the next state is IDLE.
- Abort: e=0 sampled while in DRIVE forces IDLE next cycle. y is 0 from that cycle. There is no done pulse, count is unchanged and no GAP is taken.
- e=0 in GAP does not shorten the gap. e=0 in IDLE only deasserts in_ready.
- y is exactly one-hot in DRIVE and all-zero in every other state. It never glitches to more than one bit high.
- rst high in any state returns to reset values at that edge. Reset takes priority over accept, abort and count update.
- count saturation: at all ones a further completion leaves count unchanged. There is no wrap.

## Timing
- Accept at edge N: y is one-hot for cycles N+1 through N+PULSE_LEN, and busy is high over the same span.
- done is high in cycle N+PULSE_LEN only. count shows the increment from cycle N+PULSE_LEN+1.
- GAP occupies cycles N+PULSE_LEN+1 through N+PULSE_LEN+GAP_LEN.
- in_ready returns high in cycle N+PULSE_LEN+GAP_LEN+1, given e=1.
- Minimum spacing between strobe starts is PULSE_LEN+GAP_LEN+1 cycles. With GAP_LEN=0 there is still one y=0 cycle (the IDLE accept cycle) between back-to-back pulses.
- Abort latency: e low sampled at edge M in DRIVE gives y=0 and busy=0 from cycle M+1. in_ready rises as soon as e returns high.
- Input-to-output latency: exactly 1 cycle from the accepting edge. There is no combinational path from code to y.

## Test plan
- Reset then single accept, defaults (PULSE_LEN=4, GAP_LEN=1), code=2 at edge 10 -> y=4'b0100 for cycles 11-14, done only in cycle 14, count=1 from cycle 15, y=0 in cycle 15, in_ready=1 in cycle 16.
- All codes back-to-back with in_valid held high, GAP_LEN=0, PULSE_LEN=1 -> y steps 0001,0000,0010,0000,0100,0000,1000, one y=0 cycle between each, count=4.
- Abort: code=3 accepted, e dropped in the second DRIVE cycle -> y=0 next cycle, done never asserted, count unchanged, no GAP, in_ready=1 once e returns.
- Reset mid-pulse: rst asserted in the third DRIVE cycle -> y=0, busy=0, done=0, count=0 at the following cycle; in_ready=0 while rst is high.
- Ignored input: in_valid with e=0, and in_valid pulsed during DRIVE and GAP -> no state change, no extra pulses, count increments only once per accepted code.
- Saturation, CNT_W=2: 5 completed pulses -> count reads 1,2,3,3,3.

Source files
------------

// File: rtl/decoder_2_4_strobe.sv
// decoder_2_4_strobe: handshaked 2-to-4 decoder driving timed one-hot strobes with guard gap and completion count
module decoder_2_4_strobe #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       code,
  output logic [3:0]       y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);
  if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_pulse
    $error("PULSE_LEN must be 1..255");
  end
  if (GAP_LEN < 0 || GAP_LEN > 255) begin : g_bad_gap
    $error("GAP_LEN must be 0..255");
  end
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
  localparam logic [7:0] PL = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GL = 8'(GAP_LEN - 1);
  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       y_q, y_d;
  logic             busy_q, busy_d, done_q, done_d;
  assign in_ready = e & (state_q == IDLE) & ~rst;
  assign y        = y_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  // Outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    count_d = count_q;
    case (state_q)
      IDLE: if (e && in_valid) begin
        state_d = DRIVE;
        cnt_d   = PL;
        code_d  = code;
      end
      DRIVE: if (!e) begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end else if (cnt_q == 8'd0) begin
        state_d = GAP_LEN == 0 ? IDLE : GAP;
        cnt_d   = GAP_LEN == 0 ? 8'd0 : GL;
        count_d = &count_q ? count_q : count_q + CNT_W'(1);
      end else cnt_d = cnt_q - 8'd1;
      GAP: begin
        state_d = cnt_q == 8'd0 ? IDLE : GAP;
        cnt_d   = cnt_q == 8'd0 ? 8'd0 : cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    y_d    = state_d == DRIVE ? 4'b0001 << code_d : 4'b0000;
    done_d = state_d == DRIVE && cnt_d == 8'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      code_q  <= 2'd0;
      count_q <= '0;
      y_q     <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      count_q <= count_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_decoder_2_4_strobe.sv
// tb_decoder_2_4_strobe: table-driven and hand-sequenced checks of two decoder configurations
module tb_decoder_2_4_strobe;
  typedef struct {
    logic       rst, e, v;
    logic [1:0] code;
    logic [3:0] y;
    logic       busy, done, rdy;
    logic [7:0] cnt;
  } vec_t;
  logic       clk;
  logic       rst_a, e_a, v_a, rdy_a, busy_a, done_a;
  logic [1:0] code_a;
  logic [3:0] y_a;
  logic [7:0] count_a;
  logic       rst_b, e_b, v_b, rdy_b, busy_b, done_b;
  logic [1:0] code_b;
  logic [3:0] y_b;
  logic [1:0] count_b;
  vec_t       exp_q[$];
  vec_t       tab[27];
  int         n_vec = 0;
  int         n_err = 0;
  decoder_2_4_strobe u_a (
    .clk(clk), .rst(rst_a), .e(e_a), .in_valid(v_a), .in_ready(rdy_a), .code(code_a),
    .y(y_a), .busy(busy_a), .done(done_a), .count(count_a)
  );
  decoder_2_4_strobe #(.PULSE_LEN(1), .GAP_LEN(0), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst_b), .e(e_b), .in_valid(v_b), .in_ready(rdy_b), .code(code_b),
    .y(y_b), .busy(busy_b), .done(done_b), .count(count_b)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic r, input logic en, input logic vl, input logic [1:0] c,
                              input logic [3:0] yy, input logic bs, input logic dn, input logic rd,
                              input logic [7:0] ct);
    vec_t t;
    t.rst = r; t.e = en; t.v = vl; t.code = c;
    t.y = yy; t.busy = bs; t.done = dn; t.rdy = rd; t.cnt = ct;
    return t;
  endfunction
  task automatic step(input bit sel_b, input vec_t v, input string name);
    vec_t       x;
    logic [3:0] gy;
    logic       gb, gd, gr;
    logic [7:0] gc;
    @(negedge clk);
    rst_a = sel_b ? 1'b1 : v.rst; e_a = sel_b ? 1'b0 : v.e; v_a = sel_b ? 1'b0 : v.v; code_a = v.code;
    rst_b = sel_b ? v.rst : 1'b1; e_b = sel_b ? v.e : 1'b0; v_b = sel_b ? v.v : 1'b0; code_b = v.code;
    exp_q.push_back(v);
    #1;
    x  = exp_q.pop_front();
    gy = sel_b ? y_b : y_a;
    gb = sel_b ? busy_b : busy_a;
    gd = sel_b ? done_b : done_a;
    gr = sel_b ? rdy_b : rdy_a;
    gc = sel_b ? {6'd0, count_b} : count_a;
    n_vec++;
    if (gy !== x.y || gb !== x.busy || gd !== x.done || gr !== x.rdy || gc !== x.cnt) begin
      n_err++;
      $display("FAIL %s: got y=%b busy=%b done=%b rdy=%b count=%0d, want y=%b busy=%b done=%b rdy=%b count=%0d",
               name, gy, gb, gd, gr, gc, x.y, x.busy, x.done, x.rdy, x.cnt);
    end
  endtask
  initial begin
    rst_a = 1'b1; e_a = 1'b0; v_a = 1'b0; code_a = 2'd0;
    rst_b = 1'b1; e_b = 1'b0; v_b = 1'b0; code_b = 2'd0;
    //            rst e  v  code  y        busy done rdy count
    tab[0]  = mk(1, 1, 1, 2, 4'b0000, 0, 0, 0, 0);
    tab[1]  = mk(0, 1, 0, 0, 4'b0000, 0, 0, 1, 0);
    tab[2]  = mk(0, 1, 1, 2, 4'b0000, 0, 0, 1, 0);
    tab[3]  = mk(0, 1, 0, 0, 4'b0100, 1, 0, 0, 0);
    tab[4]  = mk(0, 1, 1, 1, 4'b0100, 1, 0, 0, 0);
    tab[5]  = mk(0, 1, 0, 0, 4'b0100, 1, 0, 0, 0);
    tab[6]  = mk(0, 1, 0, 0, 4'b0100, 1, 1, 0, 0);
    tab[7]  = mk(0, 1, 1, 3, 4'b0000, 1, 0, 0, 1);
    tab[8]  = mk(0, 0, 1, 3, 4'b0000, 0, 0, 0, 1);
    tab[9]  = mk(0, 1, 0, 0, 4'b0000, 0, 0, 1, 1);
    tab[10] = mk(0, 1, 1, 3, 4'b0000, 0, 0, 1, 1);
    tab[11] = mk(0, 1, 0, 0, 4'b1000, 1, 0, 0, 1);
    tab[12] = mk(0, 0, 0, 0, 4'b1000, 1, 0, 0, 1);
    tab[13] = mk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 1);
    tab[14] = mk(0, 1, 0, 0, 4'b0000, 0, 0, 1, 1);
    tab[15] = mk(0, 1, 1, 0, 4'b0000, 0, 0, 1, 1);
    tab[16] = mk(0, 1, 0, 0, 4'b0001, 1, 0, 0, 1);
    tab[17] = mk(0, 1, 0, 0, 4'b0001, 1, 0, 0, 1);
    tab[18] = mk(1, 1, 1, 1, 4'b0001, 1, 0, 0, 1);
    tab[19] = mk(0, 1, 0, 0, 4'b0000, 0, 0, 1, 0);
    tab[20] = mk(0, 1, 1, 1, 4'b0000, 0, 0, 1, 0);
    tab[21] = mk(0, 1, 0, 0, 4'b0010, 1, 0, 0, 0);
    tab[22] = mk(0, 1, 0, 0, 4'b0010, 1, 0, 0, 0);
    tab[23] = mk(0, 1, 0, 0, 4'b0010, 1, 0, 0, 0);
    tab[24] = mk(0, 1, 0, 0, 4'b0010, 1, 1, 0, 0);
    tab[25] = mk(0, 0, 0, 0, 4'b0000, 1, 0, 0, 1);
    tab[26] = mk(0, 1, 0, 0, 4'b0000, 0, 0, 1, 1);
    for (int i = 0; i < 27; i++) step(1'b0, tab[i], $sformatf("dflt_row%0d", i));
    // Back-to-back pulses with valid held high, then saturation of the 2-bit counter.
    step(1'b1, mk(1, 1, 1, 0, 4'b0000, 0, 0, 0, 0), "b2b_reset");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, mk(0, 1, 1, 2'(i % 4), 4'b0000, 0, 0, 1, 8'(i < 3 ? i : 3)),
           $sformatf("b2b_idle%0d", i));
      step(1'b1, mk(0, 1, 1, 2'((i + 1) % 4), 4'(1 << (i % 4)), 1, 1, 0, 8'(i < 3 ? i : 3)),
           $sformatf("b2b_drive%0d", i));
    end
    step(1'b1, mk(0, 1, 0, 0, 4'b0000, 0, 0, 1, 3), "sat_final");
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
